// File: rtl/sync_rw_memory.sv
// Single-port synchronous read/write memory with a registered read port and a
// one-cycle acknowledge pulse for every accepted access.
`timescale 1ns/1ps

module sync_rw_memory #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  response
);

   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
   logic                  addr_ok;
   logic                  do_write;
   logic                  do_read;

   // A full-size array makes every address legal; only compare when the
   // address space is larger than the storage.
   generate
      if (MEM_SIZE >= (2 ** ADDR_WIDTH)) begin : g_full
         assign addr_ok = 1'b1;
      end else begin : g_partial
         localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = MEM_SIZE[ADDR_WIDTH-1:0];
         assign addr_ok = (addr < MEM_LIMIT);
      end
   endgenerate

   // Simultaneous wr and rd is a conflict: the request is dropped entirely.
   always_comb begin
      do_write = 1'b0;
      do_read  = 1'b0;
      if (addr_ok) begin
         do_write = wr && !rd;
         do_read  = rd && !wr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i] <= '0;
         end
         rdata    <= '0;
         response <= 1'b0;
      end else begin
         response <= do_write || do_read;
         if (do_write) begin
            mem[addr] <= wdata;
         end
         if (do_read) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: tb/tb_sync_rw_memory.sv
// Directed bench for sync_rw_memory: inputs change 1ns after a rising edge,
// outputs are sampled 1ns after the edge that consumed them.
`timescale 1ns/1ps

module tb_sync_rw_memory;

   logic        clk;
   logic        reset;
   logic        wr;
   logic        rd;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        response;

   int checks;
   int errors;

   sync_rw_memory #(
      .ADDR_WIDTH (4),
      .DATA_WIDTH (32),
      .MEM_SIZE   (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .rd       (rd),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .response (response)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Present one request, let it be sampled, and return 1ns after that edge.
   task automatic access(input logic w, input logic r, input logic [3:0] a,
                         input logic [31:0] d);
      wr    = w;
      rd    = r;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      wr     = 1'b0;
      rd     = 1'b0;
      addr   = '0;
      wdata  = '0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_rdata", rdata, 32'h0);
      check("reset_response", {31'b0, response}, 32'h0);
      reset = 1'b1;

      for (int i = 0; i < 16; i++) begin
         access(1'b0, 1'b1, 4'(i), 32'h0);
         check($sformatf("reset_read_data[%0d]", i), rdata, 32'h0);
         check($sformatf("reset_read_resp[%0d]", i), {31'b0, response}, 32'h1);
      end

      access(1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
      check("wr3_resp", {31'b0, response}, 32'h1);
      check("wr3_rdata_hold", rdata, 32'h0);
      access(1'b0, 1'b1, 4'd3, 32'h0);
      check("rd3_data", rdata, 32'hDEADBEEF);
      check("rd3_resp", {31'b0, response}, 32'h1);

      for (int i = 0; i < 16; i++) begin
         access(1'b1, 1'b0, 4'(i), 32'(i) * 32'h01010101);
         check($sformatf("sweep_wr_resp[%0d]", i), {31'b0, response}, 32'h1);
      end
      for (int i = 0; i < 16; i++) begin
         access(1'b0, 1'b1, 4'(i), 32'h0);
         check($sformatf("sweep_rd_data[%0d]", i), rdata, 32'(i) * 32'h01010101);
         check($sformatf("sweep_rd_resp[%0d]", i), {31'b0, response}, 32'h1);
      end

      access(1'b1, 1'b1, 4'd5, 32'h12345678);
      check("conflict_resp", {31'b0, response}, 32'h0);
      check("conflict_rdata_hold", rdata, 32'h0F0F0F0F);
      access(1'b0, 1'b1, 4'd5, 32'h0);
      check("after_conflict_rd5", rdata, 32'h05050505);
      check("after_conflict_resp", {31'b0, response}, 32'h1);
      access(1'b0, 1'b0, 4'd5, 32'h0);
      check("idle_resp", {31'b0, response}, 32'h0);
      check("idle_rdata_hold", rdata, 32'h05050505);

      access(1'b1, 1'b0, 4'd7, 32'hA5A5A5A5);
      check("wr7_resp", {31'b0, response}, 32'h1);
      access(1'b0, 1'b1, 4'd7, 32'h0);
      check("rd7_data", rdata, 32'hA5A5A5A5);
      wr = 1'b0;
      rd = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("midreset_rdata", rdata, 32'h0);
      check("midreset_resp", {31'b0, response}, 32'h0);
      #2 reset = 1'b1;
      access(1'b0, 1'b1, 4'd7, 32'h0);
      check("postreset_rd7", rdata, 32'h0);
      check("postreset_resp", {31'b0, response}, 32'h1);
      access(1'b0, 1'b1, 4'd3, 32'h0);
      check("postreset_rd3", rdata, 32'h0);

      access(1'b1, 1'b0, 4'd8, 32'h00000088);
      access(1'b1, 1'b0, 4'd10, 32'h000000AA);
      access(1'b1, 1'b0, 4'd9, 32'h00000001);
      access(1'b1, 1'b0, 4'd9, 32'h00000002);
      access(1'b0, 1'b1, 4'd9, 32'h0);
      check("overwrite_rd9", rdata, 32'h00000002);
      access(1'b0, 1'b1, 4'd8, 32'h0);
      check("neighbour_rd8", rdata, 32'h00000088);
      access(1'b0, 1'b1, 4'd10, 32'h0);
      check("neighbour_rd10", rdata, 32'h000000AA);
      access(1'b0, 1'b0, 4'd0, 32'h0);
      check("final_idle_resp", {31'b0, response}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_rw_memory.md
Name: sync_rw_memory

Overview:
- Single-port synchronous read/write memory of MEM_SIZE words, DATA_WIDTH bits each.
- Accepts one write or one read per clock cycle.
- Returns read data and a one-cycle `response` acknowledge, both registered.
- Sits behind the memory interface bundle as the storage target driven by the verification program.

Parameters:
- ADDR_WIDTH, 4: width of `addr`.
- DATA_WIDTH, 32: width of `wdata` and `rdata`, i.e. the word size.
- MEM_SIZE, 16: number of words. Must be at most 2**ADDR_WIDTH.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- wr, input, 1: write request, sampled at the rising edge of clk.
- rd, input, 1: read request, sampled at the rising edge of clk.
- addr, input, ADDR_WIDTH: word address for the current request.
- wdata, input, DATA_WIDTH: write data, used when wr is accepted.
- rdata, output, DATA_WIDTH: registered read data.
- response, output, 1: registered one-cycle acknowledge of an accepted access.

Behaviour:
- Reset (reset=0, asynchronous assertion):
  - All MEM_SIZE words are cleared to 0.
  - rdata=0, response=0.
  - State holds while reset is low; wr/rd are ignored.
  - Deassertion takes effect at the next rising edge; the first access can be sampled on that edge.
- Legal address: addr < MEM_SIZE.
- Write (wr=1, rd=0, legal addr) at rising edge:
  - mem[addr] <= wdata.
  - response <= 1.
  - rdata holds its previous value.
- Read (rd=1, wr=0, legal addr) at rising edge:
  - rdata <= mem[addr], where mem[addr] is the pre-edge contents.
  - response <= 1.
  - rdata is valid in the cycle in which response=1, i.e. one-cycle read latency.
- Idle (wr=0, rd=0): response <= 0; rdata and memory hold.
- Conflict (wr=1 and rd=1):
  - No access: memory unchanged, rdata holds.
  - response <= 0. The request is dropped.
- Out-of-range address (addr >= MEM_SIZE, possible only when MEM_SIZE < 2**ADDR_WIDTH):
  - No access, memory unchanged, rdata holds.
  - response <= 0.
- Handshake and throughput:
  - response is a pulse: high exactly in the cycle after each accepted edge.
  - Back-to-back accepted accesses keep response high continuously.
  - No backpressure; one access accepted per cycle.
- Read-after-write to the same address on consecutive cycles returns the newly written data.
- Memory contents persist indefinitely until overwritten or reset.
- Reset mid-operation: a pending response and rdata are cleared immediately; the memory is cleared.
- No X propagation: rdata must never be X after reset, including reads of never-written words, which return 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read addr 0..15 → every rdata=0, response=1 on each read.
- Write/read-back: write addr 3 = 32'hDEADBEEF, then read addr 3 → rdata=32'hDEADBEEF one cycle after the read edge; response=1 after both the write and the read edges.
- Full sweep: write addr i = i*32'h01010101 for i=0..15 back-to-back, then read 0..15 back-to-back → matching data, response continuously 1.
- Conflict/idle: wr=rd=1 at addr 5 with wdata=32'h12345678 → response=0, rdata unchanged; a subsequent read of addr 5 returns its old value. Idle cycle → response=0.
- Reset mid-operation: write addr 7 = 32'hA5A5A5A5, pulse reset=0 between clock edges → rdata and response drop to 0 immediately; a subsequent read of addr 7 returns 0.
- Overwrite: write addr 9 = 1, then 2 → read of addr 9 returns 2; addresses 8 and 10 are unaffected.
